mux_stream_rr: RTL and testbench
================================

# mux_stream_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshakes. It succeeds the fixed 4:1 combinational mux by generalising data width and channel count, adding per-channel flow control and a one-entry output register, and offering two selection modes: fixed select or round-robin arbitration. It sits between multiple producer streams and a single downstream consumer.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels, 2..16.
- `SEL_W`, 2: select/channel-index width; must equal `$clog2(CHANNELS)`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: per-channel valid.
- `in_ready` out CHANNELS: per-channel ready (combinational).
- `mode` in 1: 0 = fixed select, 1 = round-robin.
- `sel` in SEL_W: channel index used in fixed mode.
- `out_data` out WIDTH: registered output data.
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: downstream accepts.
- `out_ch` out SEL_W: source channel of the current output beat.

## Operation
- `load_en = !out_valid || out_ready`.
- Grant `g` is computed combinationally each cycle. At most one `in_ready` bit is high, and only `in_ready[g]` can be high.
- Fixed mode: `g = sel`. `in_ready[sel] = load_en`. If `sel >= CHANNELS`, there is no grant and all `in_ready` are 0.
- Round-robin mode:
  - Pointer `ptr` (SEL_W bits) names the highest-priority channel.
  - `g` is the first channel with `in_valid` high, scanning `ptr, ptr+1, …` modulo CHANNELS.
  - `in_ready[g] = load_en && |in_valid`.
  - On a transfer, `ptr <= (g+1) mod CHANNELS`. Wrap uses modulo CHANNELS, not 2^SEL_W.
- A transfer occurs on `in_valid[g] && in_ready[g]`. It loads `out_data <= in_data[g]`, `out_ch <= g`, and `out_valid <= 1`.
- If `load_en` is high and there is no transfer, `out_valid <= 0`.
- If `load_en` is low, the output register holds. `out_data` and `out_ch` stay stable while `out_valid && !out_ready`.
- A change of `sel` or `mode` affects only the grant for the current cycle. A beat already registered keeps its `out_ch`. `ptr` is not modified by mode changes.
- No beat is ever dropped or duplicated.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`. `in_ready` is combinational and is 0 while `out_valid=0` only if there is no grant.
- Latency: an input accepted at edge N appears with `out_valid=1` after edge N.
- Throughput: one beat per cycle with `out_ready` held high.
- Simultaneous drain and load in the same cycle is allowed and required. This is the full-throughput case.
- `rst` asserted mid-transfer: the registered beat is discarded and `ptr` returns to 0 on that edge. `rst` takes priority over a load.
- `in_ready` has no dependency on `out_valid` other than through `load_en`. There is no combinational path from `in_valid` to `in_ready` in fixed mode.

## Configuration
- `MUX_ROUND_ROBIN_EN` defined: the round-robin logic and `ptr` are compiled in, and the `mode` input is honoured.
- Not defined: `ptr` and the round-robin logic are omitted. `mode` is ignored and the block always operates in fixed-select mode. The port list is unchanged.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.

- **Reset:** assert `rst` for 2 cycles with all inputs valid. Required: `out_valid=0`, `out_data=0x00`, `out_ch=0`. After release in mode 1, the first grant is channel 0.
- **Fixed select:** mode=0, sel=2, `in_data` = {0x44,0x33,0x22,0x11}, all valid, `out_ready=1`. Required: `in_ready=4'b0100`, and one cycle later `out_data=0x33`, `out_ch=2`. Repeat with sel=1 and require `0x22`.
- **Backpressure:** a beat 0xA5 is registered and `out_ready=0` for 3 cycles. Required: all `in_ready=0`, and `out_data` stays 0xA5 throughout. On `out_ready=1`, a new beat loads on the same edge.
- **Round-robin fairness:** mode=1, all 4 valid continuously, `out_ready=1`. Required: `out_ch` sequence 0,1,2,3,0,1 with one beat per cycle.
- **Round-robin skip and wrap:** mode=1, only channels 1 and 3 valid, ptr=0. Required: grant sequence 1,3,1,3.
- **Reset mid-stream:** assert `rst` while `out_valid=1` and `out_ready=0`. Required: `out_valid=0` next cycle, and no stale beat appears afterwards.

Source files
------------

// File: rtl/mux_stream_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_rr_if
// Brief    : Handshake bundle between N producer streams and one consumer.
// Revision : 1.0
// ============================================================================
interface mux_stream_rr_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) ();
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SEL_W-1:0]          out_ch;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface
`default_nettype wire

// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_rr
// Brief    : Registered N:1 stream mux, fixed select or round-robin
//            (round-robin compiled in with MUX_ROUND_ROBIN_EN).
// Revision : 1.0
// ============================================================================
module mux_stream_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic           clk,
   input  logic           rst,
   mux_stream_rr_if.slave s_if
);

   localparam logic [SEL_W:0] c_NUM_CH  = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W:0] c_LAST_CH = (SEL_W+1)'(CHANNELS-1);

   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [SEL_W-1:0]    out_ch_q, out_ch_d;

   logic                w_load_en;
   logic                w_grant_ok;
   logic [SEL_W-1:0]    w_grant;
   logic                w_fix_ok;
   logic [CHANNELS-1:0] w_in_ready;
   logic                w_xfer;

   assign w_load_en = !out_valid_q || s_if.out_ready;
   assign w_fix_ok  = ({1'b0, s_if.sel} < c_NUM_CH);

`ifdef MUX_ROUND_ROBIN_EN
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] w_rr_grant;
   logic             w_rr_ok;
   logic [SEL_W:0]   w_scan_idx;

   // First valid channel at or after ptr, wrapping modulo CHANNELS.
   always_comb begin
      w_rr_grant = '0;
      w_rr_ok    = 1'b0;
      w_scan_idx = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_scan_idx = {1'b0, ptr_q} + (SEL_W+1)'(i);
         if (w_scan_idx >= c_NUM_CH) begin
            w_scan_idx = w_scan_idx - c_NUM_CH;
         end
         if (!w_rr_ok && s_if.in_valid[w_scan_idx[SEL_W-1:0]]) begin
            w_rr_ok    = 1'b1;
            w_rr_grant = w_scan_idx[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      if (s_if.mode) begin
         w_grant    = w_rr_grant;
         w_grant_ok = w_rr_ok;
      end else begin
         w_grant    = s_if.sel;
         w_grant_ok = w_fix_ok;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (w_xfer && s_if.mode) begin
         if ({1'b0, w_grant} == c_LAST_CH) begin
            ptr_d = '0;
         end else begin
            ptr_d = w_grant + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic w_unused_mode;
   assign w_unused_mode = s_if.mode;
   assign w_grant       = s_if.sel;
   assign w_grant_ok    = w_fix_ok;
`endif

   // At most one ready bit; fixed mode never looks at in_valid here.
   always_comb begin
      w_in_ready = '0;
      if (w_grant_ok && w_load_en) begin
         w_in_ready[w_grant] = 1'b1;
      end
   end

   assign w_xfer = w_grant_ok && s_if.in_valid[w_grant] && w_in_ready[w_grant];

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (w_load_en) begin
         out_valid_d = w_xfer;
         if (w_xfer) begin
            out_data_d = s_if.in_data[w_grant*WIDTH +: WIDTH];
            out_ch_d   = w_grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign s_if.in_ready  = w_in_ready;
   assign s_if.out_data  = out_data_q;
   assign s_if.out_valid = out_valid_q;
   assign s_if.out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_stream_rr
// Brief    : Vector table, corner sequences and random traffic vs. a model.
// Revision : 1.0
// ============================================================================
module tb_mux_stream_rr;

`ifdef MUX_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks = 0;
   int   passed = 0;

   mux_stream_rr_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus ();

   mux_stream_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .s_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: what the output register should hold, plus RR pointer.
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   int         m_ch    = 0;
   int         m_ptr   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive_cycle(input logic r, input logic md, input logic [1:0] s,
                              input logic [3:0] v, input logic [31:0] d, input logic ordy,
                              output logic [3:0] rdy_seen);
      bit         ok;
      bit         load;
      int         g;
      int         c;
      logic [3:0] e_rdy;
      rst           = r;
      bus.mode      = md;
      bus.sel       = s;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #2;
      ok = 1'b0;
      g  = 0;
      if (RR_EN && md) begin
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!ok && v[c]) begin
               ok = 1'b1;
               g  = c;
            end
         end
      end else begin
         g  = int'(s);
         ok = (g < 4);
      end
      load  = !m_valid || ordy;
      e_rdy = 4'b0000;
      if (ok && load) e_rdy[g] = 1'b1;
      rdy_seen = bus.in_ready;
      chk("in_ready", {28'd0, rdy_seen}, {28'd0, e_rdy});
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ch    = 0;
         m_ptr   = 0;
      end else if (load) begin
         m_valid = ok && v[g];
         if (m_valid) begin
            m_data = d[g*8 +: 8];
            m_ch   = g;
            if (RR_EN && md) m_ptr = (g + 1) % 4;
         end
      end
      #1;
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      if (m_valid || r) begin
         chk("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
         chk("out_ch", {30'd0, bus.out_ch}, m_ch);
      end
   endtask

   typedef struct {
      logic        r;
      logic        md;
      logic [1:0]  s;
      logic [3:0]  v;
      logic [31:0] d;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_od;
      logic [1:0]  e_ch;
   } vec_t;

   vec_t tbl[11];
   int   fair[6] = '{0, 1, 2, 3, 0, 1};
   int   skip[4] = '{1, 3, 1, 3};

   initial begin
      logic [3:0] rs;
      tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{1'b1, 1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[2]  = '{1'b0, 1'b1, 2'd3, 4'hF, 32'h44332211, 1'b1,
                  RR_EN ? 4'b0001 : 4'b1000, 1'b1, RR_EN ? 8'h11 : 8'h44, RR_EN ? 2'd0 : 2'd3};
      tbl[3]  = '{1'b0, 1'b0, 2'd2, 4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      tbl[4]  = '{1'b0, 1'b0, 2'd1, 4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      tbl[5]  = '{1'b0, 1'b0, 2'd0, 4'hF, 32'h443322A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0};
      tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'hF, 32'h44332255, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
      tbl[7]  = '{1'b0, 1'b0, 2'd0, 4'hF, 32'h44332255, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
      tbl[8]  = '{1'b0, 1'b0, 2'd0, 4'hF, 32'h44332255, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
      tbl[9]  = '{1'b0, 1'b0, 2'd0, 4'hF, 32'h44332255, 1'b1, 4'b0001, 1'b1, 8'h55, 2'd0};
      tbl[10] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h44332255, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};

      rst           = 1'b1;
      bus.mode      = 1'b0;
      bus.sel       = 2'd0;
      bus.in_valid  = 4'h0;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         drive_cycle(tbl[i].r, tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].ordy, rs);
         chk("tbl_in_ready", {28'd0, rs}, {28'd0, tbl[i].e_rdy});
         chk("tbl_out_valid", {31'd0, bus.out_valid}, {31'd0, tbl[i].e_ov});
         if (tbl[i].e_ov || tbl[i].r) begin
            chk("tbl_out_data", {24'd0, bus.out_data}, {24'd0, tbl[i].e_od});
            chk("tbl_out_ch", {30'd0, bus.out_ch}, {30'd0, tbl[i].e_ch});
         end
      end

      // Reset while a beat is stalled: it must vanish and never reappear.
      drive_cycle(1'b0, 1'b0, 2'd1, 4'hF, 32'h00BE0000, 1'b0, rs);
      chk("mid_loaded", {31'd0, bus.out_valid}, 32'd1);
      drive_cycle(1'b1, 1'b0, 2'd1, 4'hF, 32'h00BE0000, 1'b0, rs);
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 2'd1, 4'h0, 32'h00BE0000, 1'b1, rs);
         chk("mid_no_stale", {31'd0, bus.out_valid}, 32'd0);
      end

      if (RR_EN) begin
         drive_cycle(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1, rs);
         for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b1, 2'd2, 4'hF, 32'hD3C2B1A0, 1'b1, rs);
            chk("rr_fair_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("rr_fair_ch", {30'd0, bus.out_ch}, fair[i]);
         end
         drive_cycle(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1, rs);
         for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 2'd0, 4'b1010, 32'hD3C2B1A0, 1'b1, rs);
            chk("rr_skip_ch", {30'd0, bus.out_ch}, skip[i]);
         end
      end

      for (int i = 0; i < 400; i++) begin
         drive_cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 4'($urandom), $urandom,
                     ($urandom_range(0, 3) != 0), rs);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
